// File: rtl/seed_loader_pkg.sv
// Shared types and constants for the seed loader: FSM state encoding and
// default sizing for the seed FIFO and data path.
package seed_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } state_t;

  localparam int unsigned DEFAULT_DEPTH = 4;
  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned PERIOD_MIN    = 1;

endpackage

// File: rtl/seed_fifo.sv
// Synchronous seed FIFO with wrap-bit pointers; no read-through bypass, so a
// pushed entry becomes visible at the head on the following cycle.
module seed_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [WIDTH-1:0] mem [DEPTH];

  assign head  = mem[rptr[AW-1:0]];
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full)
        wptr <= wptr + {{AW{1'b0}}, 1'b1};
      if (pop && !empty)
        rptr <= rptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/seed_loader.sv
// Seed loader: queues seeds and issues each as a one-cycle sel/data load
// followed by a programmable free-run gap. Optional stats via SEED_LOADER_STATS_EN.
module seed_loader
  import seed_loader_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             enable,
  input  logic [7:0]       period,
  output logic             sel,
  output logic [WIDTH-1:0] data,
  output logic             busy
`ifdef SEED_LOADER_STATS_EN
  ,
  output logic [15:0]      load_count,
  output logic             drop_seen
`endif
);

  localparam logic [7:0] PMIN = 8'(PERIOD_MIN);

  state_t           state;
  logic [7:0]       cnt;
  logic [WIDTH-1:0] head;
  logic             full;
  logic             empty;
  logic             push;
  logic             start;

  assign in_ready = !full;
  assign push     = in_valid && !full;
  // A new load may begin from IDLE or on the last cycle of a run.
  assign start    = enable && !empty &&
                    ((state == IDLE) || ((state == RUN) && (cnt == 8'd1)));

  seed_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (start),
    .wdata (in_data),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      data  <= '0;
      sel   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD;
            data  <= head;
            sel   <= 1'b1;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          cnt   <= (period < PMIN) ? PMIN : period;
          state <= RUN;
          sel   <= 1'b0;
        end
        RUN: begin
          cnt <= cnt - 8'd1;
          if (cnt == 8'd1) begin
            if (start) begin
              state <= LOAD;
              data  <= head;
              sel   <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          sel   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SEED_LOADER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_count <= '0;
      drop_seen  <= 1'b0;
    end else begin
      if ((state == LOAD) && (load_count != '1))
        load_count <= load_count + 16'd1;
      if (in_valid && !in_ready)
        drop_seen <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_seed_loader.sv
// Directed bench for seed_loader: reset, latency, spacing, backpressure,
// enable drop and mid-run reset, with hand-computed expectations.
module tb_seed_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       enable;
  logic [7:0] period;
  logic       sel;
  logic [7:0] data;
  logic       busy;
`ifdef SEED_LOADER_STATS_EN
  logic [15:0] load_count;
  logic        drop_seen;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seed_loader #(
    .DEPTH (4),
    .WIDTH (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .enable   (enable),
    .period   (period),
    .sel      (sel),
    .data     (data),
    .busy     (busy)
`ifdef SEED_LOADER_STATS_EN
    ,
    .load_count (load_count),
    .drop_seen  (drop_seen)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [7:0] v);
    in_valid = 1'b1;
    in_data  = v;
    tick();
    in_valid = 1'b0;
  endtask

  // Watches for n sel pulses carrying base, base+1, ... spaced gap cycles apart.
  task automatic collect(input string tag, input int n, input logic [7:0] base, input int gap);
    int got  = 0;
    int last = 0;
    for (int c = 1; c <= 80 && got < n; c++) begin
      tick();
      if (sel) begin
        check({tag, " data"}, 32'(data), 32'(base) + 32'(got));
        if (got > 0) check({tag, " gap"}, 32'(c - last), 32'(gap));
        last = c;
        got++;
      end
    end
    check({tag, " count"}, 32'(got), 32'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hAA;
    enable   = 1'b0;
    period   = 8'd3;

    // 1: reset
    tick();
    tick();
    check("rst sel", 32'(sel), 0);
    check("rst data", 32'(data), 0);
    check("rst busy", 32'(busy), 0);
    check("rst in_ready", 32'(in_ready), 1);
`ifdef SEED_LOADER_STATS_EN
    check("rst load_count", 32'(load_count), 0);
    check("rst drop_seen", 32'(drop_seen), 0);
`endif
    in_valid = 1'b0;
    rst_n    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post-rst sel", 32'(sel), 0);
    end

    // 2: single seed, period 3
    enable = 1'b1;
    period = 8'd3;
    push_one(8'h02);
    check("t2 N+1 sel", 32'(sel), 0);
    check("t2 N+1 busy", 32'(busy), 0);
    tick();
    check("t2 N+2 sel", 32'(sel), 1);
    check("t2 N+2 data", 32'(data), 32'h02);
    check("t2 N+2 busy", 32'(busy), 1);
    for (int i = 3; i <= 5; i++) begin
      tick();
      check("t2 run sel", 32'(sel), 0);
      check("t2 run busy", 32'(busy), 1);
    end
    tick();
    check("t2 N+6 busy", 32'(busy), 0);
    check("t2 N+6 data", 32'(data), 32'h02);

    // 3: back-to-back, period 2
    period = 8'd2;
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          in_valid = 1'b1;
          in_data  = 8'(k);
          tick();
        end
        in_valid = 1'b0;
      end
      collect("t3", 4, 8'h00, 3);
    join
    tick();
    tick();
    check("t3 last run busy", 32'(busy), 1);
    tick();
    check("t3 idle busy", 32'(busy), 0);

    // 4: full / backpressure
    enable = 1'b0;
    period = 8'd1;
    for (int k = 0; k < 4; k++) push_one(8'h10 + 8'(k));
    check("t4 full in_ready", 32'(in_ready), 0);
    in_valid = 1'b1;
    in_data  = 8'h14;
    tick();
    check("t4 held in_ready", 32'(in_ready), 0);
    check("t4 held busy", 32'(busy), 0);
    enable = 1'b1;
    tick();
    check("t4 pop sel", 32'(sel), 1);
    check("t4 pop data", 32'(data), 32'h10);
    check("t4 pop in_ready", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    check("t4 refill in_ready", 32'(in_ready), 0);
    collect("t4", 4, 8'h11, 2);
    repeat (3) tick();
    check("t4 idle busy", 32'(busy), 0);

    // 5: period 0 and enable drop
    enable = 1'b0;
    period = 8'd0;
    for (int k = 0; k < 4; k++) push_one(8'h20 + 8'(k));
    enable = 1'b1;
    collect("t5a", 2, 8'h20, 2);
    enable = 1'b0;
    tick();
    check("t5 run busy", 32'(busy), 1);
    check("t5 run sel", 32'(sel), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t5 idle sel", 32'(sel), 0);
      check("t5 idle busy", 32'(busy), 0);
    end
    check("t5 idle data", 32'(data), 32'h21);
    enable = 1'b1;
    collect("t5b", 2, 8'h22, 2);
    repeat (3) tick();

    // 6: reset mid-run
    enable = 1'b0;
    period = 8'd10;
    for (int k = 0; k < 4; k++) push_one(8'h30 + 8'(k));
    enable = 1'b1;
    tick();
    check("t6 load sel", 32'(sel), 1);
    check("t6 load data", 32'(data), 32'h30);
    repeat (4) tick();
    check("t6 run busy", 32'(busy), 1);
`ifdef SEED_LOADER_STATS_EN
    check("t6 load_count", 32'(load_count), 15);
    check("t6 drop_seen", 32'(drop_seen), 1);
`endif
    rst_n = 1'b0;
    #1;
    check("t6 rst sel", 32'(sel), 0);
    check("t6 rst data", 32'(data), 0);
    check("t6 rst busy", 32'(busy), 0);
    check("t6 rst in_ready", 32'(in_ready), 1);
`ifdef SEED_LOADER_STATS_EN
    check("t6 rst load_count", 32'(load_count), 0);
    check("t6 rst drop_seen", 32'(drop_seen), 0);
`endif
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t6 empty sel", 32'(sel), 0);
      check("t6 empty busy", 32'(busy), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seed_loader.md
Name: seed_loader

Overview:
- Upstream feeder for the load/increment lookup stage, which takes a `sel` load strobe and an 8-bit `data` seed.
- Buffers seed values arriving on a valid/ready interface in a small FIFO.
- Issues them one at a time as a single-cycle `sel` pulse with `data`.
- Between loads, the downstream counter free-runs for a programmable number of cycles.

Parameters:
- DEPTH, 4, seed FIFO entries; power of two, minimum 2.
- WIDTH, 8, seed/data width; must match the downstream data port.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream seed valid.
- in_data  input  WIDTH  seed value.
- in_ready  output  1  FIFO can accept; equals !full.
- enable  input  1  permits new loads; an in-progress run always completes.
- period  input  8  free-run cycles after each load; 0 is treated as 1; sampled in LOAD.
- sel  output  1  load strobe to the downstream stage; high exactly one cycle per seed.
- data  output  WIDTH  seed presented with `sel`; holds the last loaded value otherwise.
- busy  output  1  high when state != IDLE.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, FIFO empty, sel=0, data=0, busy=0, in_ready=1, run counter=0.
- Push: an entry is written when in_valid && in_ready at the edge. No bypass: a pushed entry is poppable the next cycle at the earliest.
- in_ready is derived from registered full only. A pop and push in the same cycle while full does not accept the push.
- FSM states: IDLE, LOAD, RUN. sel=(state==LOAD); sel is a registered decode with no combinational path from inputs.
- IDLE → LOAD when enable && !empty. At that edge: data <= FIFO head, pop one entry.
- LOAD (one cycle, sel=1):
  - cnt <= (period==0) ? 1 : period.
  - Go to RUN.
- RUN (sel=0):
  - cnt decrements each cycle.
  - In the cycle where cnt==1: if enable && !empty, go to LOAD with data <= head and pop; otherwise go to IDLE.
- Spacing: consecutive sel pulses are exactly max(period,1)+1 cycles apart when the FIFO never empties.
- Latency: seed accepted at edge N with FSM in IDLE, enabled → sel=1 in cycle N+2.
- enable deasserted during LOAD or RUN: the run finishes, then FSM enters IDLE and stays there. The FIFO keeps accepting until full.
- period changes outside LOAD have no effect on the current run.
- FIFO pointers are log2(DEPTH)+1 bits and wrap naturally. full = MSBs differ and the rest are equal; empty = pointers equal.
- Asserting reset mid-run clears the FIFO contents, and sel drops immediately.

Optional Feature:
- Macro SEED_LOADER_STATS_EN.
- Defined:
  - Adds output load_count (16 bits), incremented on every LOAD cycle and saturating at 16'hFFFF; reset 0.
  - Adds output drop_seen (1 bit), a sticky flag set when in_valid && !in_ready; cleared only by reset.
- Undefined: neither port nor the logic behind it exists; all other behaviour is identical.

Decomposition:
- Package seed_loader_pkg:
  - typedef enum for state_t {IDLE, LOAD, RUN}.
  - Constant default DEPTH/WIDTH.
  - Constant PERIOD_MIN=1.
- One sub-module: seed_fifo (parameterised DEPTH/WIDTH synchronous FIFO; push/pop/head/full/empty). The FSM and run counter live in seed_loader.

Test Plan:
1. Reset check: hold rst_n=0 with in_valid=1 → sel=0, data=0, busy=0, in_ready=1. Release: no sel for 3 cycles with enable=0.
2. Single seed: enable=1, period=3, push 8'h02 at edge N → sel=1, data=8'h02 in cycle N+2; busy high N+2..N+5; back to IDLE in N+6.
3. Back-to-back: enable=1, period=2, push 8'h00,8'h01,8'h02,8'h03 → four sel pulses exactly 3 cycles apart, data in order; then busy=0.
4. Full/backpressure: enable=0, push 5 seeds with DEPTH=4 → in_ready=0 after the fourth; fifth held. Assert enable → first pop occurs and the fifth is accepted one cycle later; order is preserved.
5. period=0 and enable drop: period=0 gives sel spacing of 2 cycles. Drop enable in RUN with 2 entries queued → run completes, FSM idles, entries remain; re-enable → loads resume.
6. Reset mid-run (period=10, cycle 4 of RUN, 3 queued) → sel=0, FIFO empty, data=0 immediately. With SEED_LOADER_STATS_EN defined, load_count=0 and drop_seen=0.
